// File: rtl/bus_mem_if.sv
// Request/response bundle between the cache bus and the main-memory responder.
interface bus_mem_if #(
  parameter int dma_data_width_p = 1
);
  logic                            mem_valid_i;
  logic                            mem_ready_o;
  logic                            mem_we_i;
  logic [31:0]                     mem_addr_i;
  logic [dma_data_width_p*32-1:0]  mem_wdata_i;
  logic                            mem_valid_o;
  logic [dma_data_width_p*32-1:0]  mem_data_o;

  modport master (
    output mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  mem_ready_o, mem_valid_o, mem_data_o
  );

  modport slave (
    input  mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output mem_ready_o, mem_valid_o, mem_data_o
  );
endinterface

// File: rtl/bus_mem.sv
// Single-ported main-memory responder: one request at a time, fixed-latency response pulse.
// Define BUS_MEM_RAND_LATENCY_EN to add 0-3 LFSR-driven extra cycles of latency per request.
module bus_mem #(
  parameter int dma_data_width_p = 1,
  parameter int mem_lines_p      = 1024,
  parameter int latency_p        = 4
) (
  input  logic      clk_i,
  input  logic      nreset_i,
  bus_mem_if.slave  mem
);
  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | counting down the remaining latency
  // RESP  | response pulse on mem_valid_o
  localparam int DW   = dma_data_width_p * 32;
  localparam int OFFS = 2 + $clog2(dma_data_width_p);
  localparam int IW   = $clog2(mem_lines_p);
  localparam int CW   = $clog2(latency_p + 4);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_live;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_mem [mem_lines_p];

  logic          w_ready;
  logic          w_accept;
  logic [IW-1:0] w_idx;
  logic [CW-1:0] w_lat;
  logic          w_unused_addr;

  assign w_ready       = r_live & (r_state == ST_IDLE);
  assign w_accept      = w_ready & mem.mem_valid_i;
  assign w_idx         = mem.mem_addr_i[OFFS +: IW];
  assign w_unused_addr = ^mem.mem_addr_i;

`ifdef BUS_MEM_RAND_LATENCY_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, stepped after the current value sets this request's latency
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_lfsr <= 8'h01;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_lat = CW'(latency_p) + CW'(r_lfsr[1:0]);
`else
  assign w_lat = CW'(latency_p);
`endif

  // Array has no reset so it maps onto plain RAM; writes survive a mid-request reset.
  always_ff @(posedge clk_i) begin
    if (w_accept && mem.mem_we_i) begin
      r_mem[w_idx] <= mem.mem_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_live  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data <= mem.mem_we_i ? mem.mem_wdata_i : r_mem[w_idx];
            if (w_lat == CW'(1)) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= w_lat - CW'(2);
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_ready_o = w_ready;
  assign mem.mem_valid_o = (r_state == ST_RESP);
  assign mem.mem_data_o  = r_data;
endmodule

// File: doc/bus_mem.md
# bus_mem

Single-ported main-memory responder on the memory side of the cache bus. It accepts one request at a time on the `mem_*` handshake driven by `bus`: a read or write of one `dma_data_width_p`-word beat. After a fixed, configurable latency it returns a one-cycle response pulse carrying the read data, or an acknowledgment for a write. It is the behavioural and synthesizable backing store used for single- and multi-cache system builds.

## Interface
- `dma_data_width_p`, 1: words (32-bit) per transfer beat; power of 2.
- `mem_lines_p`, 1024: storage depth in beats; power of 2.
- `latency_p`, 4: cycles from request acceptance to response; must be ≥1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `nreset_i`  in  1  reset, asynchronous and active-low.
- `mem_valid_i`  in  1  request valid from bus.
- `mem_ready_o`  out  1  responder can accept a request this cycle.
- `mem_we_i`  in  1  1 = write, 0 = read.
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  `dma_data_width_p*32`  write data.
- `mem_valid_o`  out  1  one-cycle response pulse.
- `mem_data_o`  out  `dma_data_width_p*32`  response data; meaningful only while `mem_valid_o` is high.

## Operation
- A request is accepted on a rising edge where `mem_valid_i & mem_ready_o` is high.
- Index = `mem_addr_i >> (2 + log2(dma_data_width_p))`, truncated to `log2(mem_lines_p)` bits.
  - Upper address bits are ignored, so addresses wrap (alias).
  - Address bits below the beat size are ignored.
- Write: the array entry is written on the acceptance edge. The response register is loaded with `mem_wdata_i`, so the write acknowledgment echoes the written data.
- Read: the array entry is read at acceptance and loaded into the response register.
- State machine:
  - IDLE: `mem_ready_o = 1`. On acceptance, go to RESP if the effective latency is 1; otherwise go to WAIT with `cnt = latency - 2`.
  - WAIT: decrement `cnt`; go to RESP when `cnt == 0`.
  - RESP: `mem_valid_o = 1` for exactly one cycle, then return to IDLE.
- Outside IDLE, `mem_ready_o = 0` and `mem_valid_i` is ignored. There is no queueing, and requests presented while busy are not captured.
- `mem_data_o` holds the last response value between responses.
- The array is not reset. Contents are undefined until written.

## Timing
- Reset (`nreset_i` low, asynchronous):
  - state = IDLE, `mem_valid_o = 0`, `mem_data_o = 0`, `cnt = 0`.
  - `mem_ready_o = 0` while reset is asserted; it goes to 1 in the first cycle after deassertion.
- Acceptance in cycle T gives `mem_valid_o` high in cycle T+L, where L is the effective latency (`latency_p`).
- `mem_ready_o` is low in cycles T+1 … T+L and high again in cycle T+L+1. The earliest next acceptance is cycle T+L+1, so throughput is one request per L+1 cycles.
- Reset mid-request: the pending response is dropped and no `mem_valid_o` pulse is produced. A write already accepted stays committed to the array.
- A read of an index written by the immediately previous request returns the new data.
- The counter width is `$clog2(latency_p+4)` bits, so it cannot overflow with the extra latency described below.

## Configuration
- `BUS_MEM_RAND_LATENCY_EN` defined:
  - An 8-bit LFSR with taps x^8+x^6+x^5+x^4+1 is seeded to `8'h01` on reset.
  - The LFSR advances once per accepted request, after its current value is sampled.
  - Effective latency L = `latency_p + lfsr[1:0]`, a range of 0–3 extra cycles.
  - The sequence is deterministic from reset, for stress-testing bus and cache stall handling.
- Undefined: no LFSR logic is built, and L = `latency_p` always.

## Test plan
- Reset released, no stimulus → `mem_ready_o = 1`, `mem_valid_o = 0`, `mem_data_o = 0`.
- `dma_data_width_p = 1`, `latency_p = 4`:
  - Write addr `0x10`, data `0xDEADBEEF`, accepted in cycle T → `mem_valid_o` high only in cycle T+4, `mem_data_o = 0xDEADBEEF`, `mem_ready_o` low in T+1..T+4.
  - Then read `0x10` → `mem_valid_o` 4 cycles after acceptance with data `0xDEADBEEF`.
- Aliasing: `mem_lines_p = 1024`, `dma_data_width_p = 1`. Write `0x1234` to addr `0x0000_1000`, read addr `0x0000_0000` → data `0x1234`, since the index wraps to 0.
- Back-to-back: hold `mem_valid_i` high with 3 reads → acceptances exactly 5 cycles apart, 3 response pulses, no request captured while `mem_ready_o` is low.
- Reset asserted while in WAIT after a write of `0xA5A5A5A5` to addr `0x40` → no response pulse. After reset, a read of `0x40` returns `0xA5A5A5A5`.
- With `BUS_MEM_RAND_LATENCY_EN` defined and `latency_p = 1` → latencies of consecutive requests after reset match the LFSR `[1:0]` sequence starting from seed `0x01` (first latency = 2). All latencies fall within 1–4 cycles and every response carries correct data.
